// File: rtl/mcd_pkg.sv
// Shared encodings for the multi-cycle datapath: FSM states, operand/branch codes,
// instruction field positions and the ALU control decode.
package mcd_pkg;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [1:0] SRC_REG = 2'b00;
  localparam logic [1:0] SRC_IMM = 2'b01;
  localparam logic [1:0] SRC_OFF = 2'b10;
  localparam logic [1:0] SRC_SH  = 2'b11;

  localparam logic [2:0] BR_NONE   = 3'd0;
  localparam logic [2:0] BR_ALWAYS = 3'd1;
  localparam logic [2:0] BR_Z      = 3'd2;
  localparam logic [2:0] BR_NZ     = 3'd3;
  localparam logic [2:0] BR_S      = 3'd4;
  localparam logic [2:0] BR_C      = 3'd5;
  localparam logic [2:0] BR_V      = 3'd6;

  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_PASSB = 4'd8;

  typedef struct packed {
    logic z;
    logic c;
    logic v;
    logic s;
  } flags_t;

  // alu_op: 00 add (addresses, addi), 01 sub (compares), 10 R-type from fn[2:0], 11 pass operand 2
  function automatic logic [3:0] alu_ctrl(input logic [1:0] alu_op, input logic [2:0] fn_lo);
    case (alu_op)
      2'b00:   alu_ctrl = ALU_ADD;
      2'b01:   alu_ctrl = ALU_SUB;
      2'b10:   alu_ctrl = {1'b0, fn_lo};
      default: alu_ctrl = ALU_PASSB;
    endcase
  endfunction

endpackage

// File: rtl/mcd_mem_if.sv
// Instruction and data memory ports of the multi-cycle datapath.
// Handshake: a req is held with stable addr/we/wdata until the cycle ready is seen
// alongside it; that cycle completes the access (rdata valid). ready without req is ignored.
interface mcd_mem_if #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32
);
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic [31:0]       imem_rdata;
  logic              imem_ready;
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ready;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_rdata, imem_ready, dmem_rdata, dmem_ready
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_rdata, imem_ready, dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/mcd_fsm.sv
// Sequencer for one instruction at a time: FETCH/DECODE/EXEC/MEM/WB, plus an absorbing HALT.
// Requests, retire and halted are decoded from state and forced low while rst is asserted.
module mcd_fsm import mcd_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic       pc_at_halt,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  input  logic       mem_access,
  output logic [2:0] state,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       retire,
  output logic       halted
);
  logic [2:0] state_q;
  logic [2:0] state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (pc_at_halt) state_d = S_HALT;
                else if (imem_ready) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = mem_access ? S_MEM : S_WB;
      S_MEM:    if (dmem_ready) state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  assign state    = state_q;
  assign imem_req = !rst && (state_q == S_FETCH) && !pc_at_halt;
  assign dmem_req = !rst && (state_q == S_MEM);
  assign retire   = !rst && (state_q == S_WB);
  assign halted   = !rst && (state_q == S_HALT);
endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle datapath: latched IR/A/B/ALUout/MDR/flags, register bank, ALU and branch
// target logic, sequenced by mcd_fsm and talking to stallable memories over mcd_mem_if.
module multicycle_datapath import mcd_pkg::*; #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int PC_W    = 32,
  parameter int HALT_PC = 40
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      alu_op,
  input  logic [1:0]      alu_src,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            reg_write,
  input  logic            mem_to_reg,
  input  logic [2:0]      branch_cond,
  output logic [5:0]      op,
  output logic [10:0]     fn,
  mcd_mem_if.master       mem,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            retire,
  output logic [2:0]      state_dbg
);
  localparam int MSB = DATA_W - 1;

  logic [31:0]       ir;
  logic [DATA_W-1:0] a, b, alu_out, mdr;
  flags_t            flags;
  logic [DATA_W-1:0] regs [2**REG_AW];

  logic [2:0]        state;
  logic [REG_AW-1:0] rs, rt, wa;
  logic [DATA_W-1:0] src2, alu_r, wd;
  logic [DATA_W:0]   sum_x;
  logic [3:0]        alu_fn;
  flags_t            alu_flags;
  logic              taken;
  logic [PC_W-1:0]   pc_plus4, br_target, jmp_target, pc_next;

  mcd_fsm u_fsm (
    .clk        (clk),
    .rst        (rst),
    .pc_at_halt (pc >= PC_W'(HALT_PC)),
    .imem_ready (mem.imem_ready),
    .dmem_ready (mem.dmem_ready),
    .mem_access (mem_read | mem_write),
    .state      (state),
    .imem_req   (mem.imem_req),
    .dmem_req   (mem.dmem_req),
    .retire     (retire),
    .halted     (halted)
  );

  assign state_dbg      = state;
  assign op             = ir[31:26];
  assign fn             = ir[10:0];
  assign rs             = ir[RS_LSB +: REG_AW];
  assign rt             = ir[RT_LSB +: REG_AW];
  assign mem.imem_addr  = pc;
  assign mem.dmem_addr  = alu_out;
  assign mem.dmem_wdata = b;
  assign mem.dmem_we    = mem.dmem_req & mem_write;

  always_comb begin
    case (alu_src)
      SRC_REG: src2 = b;
      SRC_IMM: src2 = DATA_W'($signed(ir[20:0]));
      SRC_OFF: src2 = DATA_W'($signed(ir[15:0]));
      default: src2 = DATA_W'(ir[15:11]);
    endcase
  end

  assign alu_fn = alu_ctrl(alu_op, ir[2:0]);

  always_comb begin
    alu_r       = '0;
    sum_x       = '0;
    alu_flags   = '0;
    case (alu_fn)
      ALU_ADD: begin
        sum_x       = {1'b0, a} + {1'b0, src2};
        alu_r       = sum_x[MSB:0];
        alu_flags.c = sum_x[DATA_W];
        alu_flags.v = (a[MSB] == src2[MSB]) && (alu_r[MSB] != a[MSB]);
      end
      ALU_SUB: begin
        // carry is "no borrow": a + ~b + 1
        sum_x       = {1'b0, a} + {1'b0, ~src2} + (DATA_W+1)'(1);
        alu_r       = sum_x[MSB:0];
        alu_flags.c = sum_x[DATA_W];
        alu_flags.v = (a[MSB] != src2[MSB]) && (alu_r[MSB] != a[MSB]);
      end
      ALU_AND: alu_r = a & src2;
      ALU_OR:  alu_r = a | src2;
      ALU_XOR: alu_r = a ^ src2;
      ALU_SLL: alu_r = a << src2[4:0];
      ALU_SRL: alu_r = a >> src2[4:0];
      ALU_SRA: alu_r = DATA_W'($signed(a) >>> src2[4:0]);
      default: alu_r = src2;
    endcase
    alu_flags.z = (alu_r == '0);
    alu_flags.s = alu_r[MSB];
  end

  // Branch and jump displacements are word counts, hence the appended 2'b00.
  assign pc_plus4   = pc + PC_W'(4);
  assign br_target  = pc_plus4 + PC_W'($signed({ir[15:0], 2'b00}));
  assign jmp_target = pc_plus4 + PC_W'($signed({ir[25:0], 2'b00}));

  always_comb begin
    case (branch_cond)
      BR_NONE:   taken = 1'b0;
      BR_ALWAYS: taken = 1'b1;
      BR_Z:      taken = flags.z;
      BR_NZ:     taken = !flags.z;
      BR_S:      taken = flags.s;
      BR_C:      taken = flags.c;
      BR_V:      taken = flags.v;
      default:   taken = 1'b0;
    endcase
    if (!taken)                         pc_next = pc_plus4;
    else if (branch_cond == BR_ALWAYS)  pc_next = jmp_target;
    else                                pc_next = br_target;
  end

  assign wa = mem_read ? rt : rs;
  assign wd = mem_to_reg ? mdr : alu_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= '0;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
      flags   <= '0;
    end else begin
      case (state)
        S_FETCH:  if (mem.imem_req && mem.imem_ready) ir <= mem.imem_rdata;
        S_DECODE: begin
          a <= regs[rs];
          b <= regs[rt];
        end
        S_EXEC: begin
          alu_out <= alu_r;
          flags   <= alu_flags;
        end
        S_MEM:    if (mem.dmem_ready && mem_read) mdr <= mem.dmem_rdata;
        S_WB:     pc <= pc_next;
        default:  ;
      endcase
    end
  end

  // Register contents survive reset; only a completed WB writes them.
  always_ff @(posedge clk) begin
    if (!rst && state == S_WB && reg_write) regs[wa] <= wd;
  end
endmodule
